// File: rtl/axi_lite_master_bridge_if.sv
// Native PicoRV32-style memory port plus AXI4-Lite master channels of the bridge.
// master = bridge side; slave = core + interconnect side.
interface axi_lite_master_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    mem_valid;
    logic                    mem_instr;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH/8-1:0] mem_wstrb;
    logic                    mem_ready;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic                    mem_err;
    logic                    timeout;

    logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
    logic [2:0]              m_axi_awprot;
    logic                    m_axi_awvalid;
    logic                    m_axi_awready;
    logic [DATA_WIDTH-1:0]   m_axi_wdata;
    logic [DATA_WIDTH/8-1:0] m_axi_wstrb;
    logic                    m_axi_wvalid;
    logic                    m_axi_wready;
    logic [1:0]              m_axi_bresp;
    logic                    m_axi_bvalid;
    logic                    m_axi_bready;
    logic [ADDR_WIDTH-1:0]   m_axi_araddr;
    logic [2:0]              m_axi_arprot;
    logic                    m_axi_arvalid;
    logic                    m_axi_arready;
    logic [DATA_WIDTH-1:0]   m_axi_rdata;
    logic [1:0]              m_axi_rresp;
    logic                    m_axi_rvalid;
    logic                    m_axi_rready;

    modport master (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata, mem_err, timeout,
        output m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bresp, m_axi_bvalid,
        output m_axi_bready,
        output m_axi_araddr, m_axi_arprot, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        output m_axi_rready
    );

    modport slave (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata, mem_err, timeout,
        input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready,
        input  m_axi_araddr, m_axi_arprot, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        input  m_axi_rready
    );
endinterface

// File: rtl/axi_lite_master_bridge.sv
// Native valid/ready memory port to single-outstanding AXI4-Lite master.
// Optional watchdog compiled in with `define AXI_BRIDGE_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for mem_valid, request fields registered on acceptance
// WR      | AW and W valid, each dropped on its own handshake
// WR_RESP | bready high, waiting for bvalid
// RD      | arvalid high, waiting for arready
// RD_DATA | rready high, waiting for rvalid
// DONE    | mem_ready pulse with mem_err, back to IDLE
module axi_lite_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    axi_lite_master_bridge_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, WR, WR_RESP, RD, RD_DATA, DONE
    } state_t;

    state_t                  state;
    logic                    mem_ready_r;
    logic                    mem_err_r;
    logic [DATA_WIDTH-1:0]   mem_rdata_r;
    logic [ADDR_WIDTH-1:0]   awaddr_r;
    logic [2:0]              awprot_r;
    logic                    awvalid_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [DATA_WIDTH/8-1:0] wstrb_r;
    logic                    wvalid_r;
    logic                    bready_r;
    logic [ADDR_WIDTH-1:0]   araddr_r;
    logic [2:0]              arprot_r;
    logic                    arvalid_r;
    logic                    rready_r;
    logic                    aw_done;
    logic                    w_done;

    // A channel counts as done if it already handshook or handshakes this cycle.
    assign aw_done = !awvalid_r || bus.m_axi_awready;
    assign w_done  = !wvalid_r  || bus.m_axi_wready;

`ifdef AXI_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wd_cnt;
    logic             timeout_r;
    logic             wd_active;
    assign wd_active   = (state == WR) || (state == WR_RESP) || (state == RD) || (state == RD_DATA);
    assign bus.timeout = timeout_r;
`else
    assign bus.timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mem_ready_r <= 1'b0;
            mem_err_r   <= 1'b0;
            mem_rdata_r <= '0;
            awaddr_r    <= '0;
            awprot_r    <= '0;
            awvalid_r   <= 1'b0;
            wdata_r     <= '0;
            wstrb_r     <= '0;
            wvalid_r    <= 1'b0;
            bready_r    <= 1'b0;
            araddr_r    <= '0;
            arprot_r    <= '0;
            arvalid_r   <= 1'b0;
            rready_r    <= 1'b0;
`ifdef AXI_BRIDGE_TIMEOUT_EN
            wd_cnt      <= '0;
            timeout_r   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.mem_valid) begin
                        if (bus.mem_wstrb != '0) begin
                            awaddr_r  <= bus.mem_addr;
                            awprot_r  <= {bus.mem_instr, 2'b00};
                            wdata_r   <= bus.mem_wdata;
                            wstrb_r   <= bus.mem_wstrb;
                            awvalid_r <= 1'b1;
                            wvalid_r  <= 1'b1;
                            state     <= WR;
                        end else begin
                            araddr_r  <= bus.mem_addr;
                            arprot_r  <= {bus.mem_instr, 2'b00};
                            arvalid_r <= 1'b1;
                            state     <= RD;
                        end
                    end
                end
                WR: begin
                    if (awvalid_r && bus.m_axi_awready) awvalid_r <= 1'b0;
                    if (wvalid_r && bus.m_axi_wready)   wvalid_r  <= 1'b0;
                    if (aw_done && w_done) begin
                        bready_r <= 1'b1;
                        state    <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bus.m_axi_bvalid) begin
                        bready_r    <= 1'b0;
                        mem_ready_r <= 1'b1;
                        mem_err_r   <= (bus.m_axi_bresp == 2'b10) || (bus.m_axi_bresp == 2'b11);
                        state       <= DONE;
                    end
                end
                RD: begin
                    if (bus.m_axi_arready) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        state     <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (bus.m_axi_rvalid) begin
                        rready_r    <= 1'b0;
                        mem_rdata_r <= bus.m_axi_rdata;
                        mem_ready_r <= 1'b1;
                        mem_err_r   <= (bus.m_axi_rresp == 2'b10) || (bus.m_axi_rresp == 2'b11);
                        state       <= DONE;
                    end
                end
                DONE: begin
                    mem_ready_r <= 1'b0;
                    mem_err_r   <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase

`ifdef AXI_BRIDGE_TIMEOUT_EN
            // Watchdog overrides whatever the case above decided this cycle.
            if (wd_active) begin
                wd_cnt <= wd_cnt + 1'b1;
                if (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    awvalid_r   <= 1'b0;
                    wvalid_r    <= 1'b0;
                    bready_r    <= 1'b0;
                    arvalid_r   <= 1'b0;
                    rready_r    <= 1'b0;
                    mem_ready_r <= 1'b1;
                    mem_err_r   <= 1'b1;
                    timeout_r   <= 1'b1;
                    if ((state == RD) || (state == RD_DATA)) mem_rdata_r <= '1;
                    state       <= DONE;
                end
            end else begin
                wd_cnt <= '0;
            end
`endif
        end
    end

    assign bus.mem_ready     = mem_ready_r;
    assign bus.mem_err       = mem_err_r;
    assign bus.mem_rdata     = mem_rdata_r;
    assign bus.m_axi_awaddr  = awaddr_r;
    assign bus.m_axi_awprot  = awprot_r;
    assign bus.m_axi_awvalid = awvalid_r;
    assign bus.m_axi_wdata   = wdata_r;
    assign bus.m_axi_wstrb   = wstrb_r;
    assign bus.m_axi_wvalid  = wvalid_r;
    assign bus.m_axi_bready  = bready_r;
    assign bus.m_axi_araddr  = araddr_r;
    assign bus.m_axi_arprot  = arprot_r;
    assign bus.m_axi_arvalid = arvalid_r;
    assign bus.m_axi_rready  = rready_r;
endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Scoreboard bench for axi_lite_master_bridge: directed native requests against a small AXI-Lite slave model.
module tb_axi_lite_master_bridge;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_lite_master_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus();

    axi_lite_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int issue_cyc = 0;
    int n_writes = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_rdata = 32'h0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    // ---------------- AXI-Lite slave model ----------------
    logic [31:0] smem [0:63];
    int          aw_wait = 0, w_wait = 0, ar_wait = 0;
    bit          ar_never = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    bit          rforce_en = 0;
    logic [31:0] rforce = 32'h0;
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, aw_hi = 0, w_hi = 0, b_count = 0;
    bit          aw_got = 0, w_got = 0;
    logic [31:0] cap_awaddr = 0, cap_wdata = 0, cap_araddr = 0;
    logic [3:0]  cap_wstrb = 0;
    logic [2:0]  cap_awprot = 0, cap_arprot = 0;
    logic        awv_q = 0, wv_q = 0, arv_q = 0, bv_q = 0, bready_q = 0, rv_q = 0, rready_q = 0;

    initial begin
        for (int i = 0; i < 64; i++) smem[i] = 32'h0;
        bus.m_axi_awready = 1'b0;
        bus.m_axi_wready  = 1'b0;
        bus.m_axi_bvalid  = 1'b0;
        bus.m_axi_bresp   = 2'b00;
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid  = 1'b0;
        bus.m_axi_rdata   = 32'h0;
        bus.m_axi_rresp   = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                bus.m_axi_awready = 1'b0;
                bus.m_axi_wready  = 1'b0;
                bus.m_axi_bvalid  = 1'b0;
                bus.m_axi_arready = 1'b0;
                bus.m_axi_rvalid  = 1'b0;
                aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
            end else begin
                // handshakes that completed at this edge
                if (awv_q && bus.m_axi_awready) begin
                    aw_got = 1; cap_awaddr = bus.m_axi_awaddr; cap_awprot = bus.m_axi_awprot;
                end
                if (wv_q && bus.m_axi_wready) begin
                    w_got = 1; cap_wdata = bus.m_axi_wdata; cap_wstrb = bus.m_axi_wstrb;
                end
                if (bv_q && bready_q) begin
                    bus.m_axi_bvalid = 1'b0;
                    b_count++;
                end
                if (aw_got && w_got) begin
                    for (int b = 0; b < 4; b++)
                        if (cap_wstrb[b]) smem[cap_awaddr[7:2]][8*b +: 8] = cap_wdata[8*b +: 8];
                    bus.m_axi_bvalid = 1'b1;
                    bus.m_axi_bresp  = bresp_cfg;
                    aw_got = 0; w_got = 0;
                end
                if (rv_q && rready_q) bus.m_axi_rvalid = 1'b0;
                if (arv_q && bus.m_axi_arready) begin
                    cap_araddr = bus.m_axi_araddr; cap_arprot = bus.m_axi_arprot;
                    bus.m_axi_rvalid = 1'b1;
                    bus.m_axi_rdata  = rforce_en ? rforce : smem[cap_araddr[7:2]];
                    bus.m_axi_rresp  = rresp_cfg;
                end
                // ready generation with per-channel wait counts
                if (bus.m_axi_awvalid) begin
                    if (!awv_q) aw_hi = 0;
                    aw_hi++;
                    bus.m_axi_awready = (aw_cnt == aw_wait);
                    aw_cnt++;
                end else begin
                    aw_cnt = 0; bus.m_axi_awready = 1'b0;
                end
                if (bus.m_axi_wvalid) begin
                    if (!wv_q) w_hi = 0;
                    w_hi++;
                    bus.m_axi_wready = (w_cnt == w_wait);
                    w_cnt++;
                end else begin
                    w_cnt = 0; bus.m_axi_wready = 1'b0;
                end
                if (bus.m_axi_arvalid) begin
                    bus.m_axi_arready = !ar_never && (ar_cnt == ar_wait);
                    ar_cnt++;
                end else begin
                    ar_cnt = 0; bus.m_axi_arready = 1'b0;
                end
            end
            awv_q = bus.m_axi_awvalid; wv_q = bus.m_axi_wvalid; arv_q = bus.m_axi_arvalid;
            bv_q = bus.m_axi_bvalid; bready_q = bus.m_axi_bready;
            rv_q = bus.m_axi_rvalid; rready_q = bus.m_axi_rready;
        end
    end

    // ---------------- monitor ----------------
    logic prev_rdy = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.mem_ready) begin
            chk("ready_one_cycle", {31'h0, prev_rdy}, 32'h0);
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_ready: got mem_ready=1 want no completion");
            end else begin
                e = sb.pop_front();
                chk("mem_err", {31'h0, bus.mem_err}, {31'h0, e.err});
                chk("mem_rdata", bus.mem_rdata, e.rdata);
                chk("latency", cyc - issue_cyc, e.lat);
            end
        end
        prev_rdy <= bus.mem_ready;
    end

    // ---------------- stimulus ----------------
    task automatic xfer(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                        input logic instr, input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        exp_t e;
        bit   got;
        e.rdata = (strb != 4'h0) ? model_rdata : exp_rd;
        if (strb == 4'h0) model_rdata = exp_rd;
        else n_writes++;
        e.err = exp_err;
        e.lat = exp_lat;
        sb.push_back(e);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wdata = data;
        bus.mem_wstrb = strb;
        bus.mem_instr = instr;
        issue_cyc = cyc;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk);
            #1;
            if (bus.mem_ready) got = 1;
        end
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'h0;
        bus.mem_instr = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL xfer_timeout: addr %h got no mem_ready want completion", addr);
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        bus.mem_valid = 1'b0;
        bus.mem_instr = 1'b0;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;
        bus.mem_wstrb = 4'h0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valids", {29'h0, bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid}, 32'h0);
        chk("rst_readies", {30'h0, bus.m_axi_bready, bus.m_axi_rready}, 32'h0);
        chk("rst_mem_flags", {29'h0, bus.mem_ready, bus.mem_err, bus.timeout}, 32'h0);
        chk("rst_mem_rdata", bus.mem_rdata, 32'h0);
        chk("rst_awaddr", bus.m_axi_awaddr, 32'h0);
        chk("rst_araddr", bus.m_axi_araddr, 32'h0);
        chk("rst_wdata", bus.m_axi_wdata, 32'h0);
        chk("rst_strb_prot", {25'h0, bus.m_axi_wstrb, bus.m_axi_awprot}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // zero-wait write then read back
        xfer(32'h100, 32'hA5A5_1234, 4'hF, 1'b0, 32'h0, 1'b0, 3);
        chk("awaddr_cap", cap_awaddr, 32'h100);
        chk("awprot_cap", {29'h0, cap_awprot}, 32'h0);
        xfer(32'h100, 32'h0, 4'h0, 1'b0, 32'hA5A5_1234, 1'b0, 3);

        // W before AW, then AW before W
        aw_wait = 4; w_wait = 0;
        xfer(32'h100, 32'h1111_BEEF, 4'h3, 1'b0, 32'h0, 1'b0, 7);
        chk("skew1_w_hi", w_hi, 1);
        chk("skew1_aw_hi", aw_hi, 5);
        aw_wait = 0; w_wait = 4;
        xfer(32'h104, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0, 1'b0, 7);
        chk("skew2_aw_hi", aw_hi, 1);
        chk("skew2_w_hi", w_hi, 5);
        w_wait = 0;
        chk("b_count_skew", b_count, n_writes);
        xfer(32'h100, 32'h0, 4'h0, 1'b0, 32'hA5A5_BEEF, 1'b0, 3);
        xfer(32'h104, 32'h0, 4'h0, 1'b1, 32'hCAFE_F00D, 1'b0, 3);
        chk("arprot_instr", {29'h0, cap_arprot}, 32'h4);
        chk("araddr_cap", cap_araddr, 32'h104);

        // error responses, then recovery
        bresp_cfg = 2'b10;
        xfer(32'h108, 32'h0000_0077, 4'hF, 1'b0, 32'h0, 1'b1, 3);
        bresp_cfg = 2'b00;
        rresp_cfg = 2'b11; rforce_en = 1; rforce = 32'h55;
        xfer(32'h10C, 32'h0, 4'h0, 1'b0, 32'h0000_0055, 1'b1, 3);
        rresp_cfg = 2'b00; rforce_en = 0;
        xfer(32'h100, 32'h0, 4'h0, 1'b0, 32'hA5A5_BEEF, 1'b0, 3);
        xfer(32'h110, 32'h0BAD_F00D, 4'hF, 1'b0, 32'h0, 1'b0, 3);
        chk("b_count_err", b_count, n_writes);

        // stalled read interrupted by reset
        ar_wait = 10;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h100;
        bus.mem_wstrb = 4'h0;
        repeat (5) @(posedge clk);
        #1;
        chk("stall_arvalid", {31'h0, bus.m_axi_arvalid}, 32'h1);
        #2;
        rst = 1'b1;
        bus.mem_valid = 1'b0;
        #1;
        chk("rst_async_arvalid", {31'h0, bus.m_axi_arvalid}, 32'h0);
        chk("rst_async_rready", {31'h0, bus.m_axi_rready}, 32'h0);
        chk("rst_async_rdata", bus.mem_rdata, 32'h0);
        model_rdata = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        ar_wait = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_idle", {30'h0, bus.m_axi_arvalid, bus.mem_ready}, 32'h0);
        xfer(32'h104, 32'h0, 4'h0, 1'b0, 32'hCAFE_F00D, 1'b0, 3);

`ifdef AXI_BRIDGE_TIMEOUT_EN
        ar_never = 1;
        xfer(32'h100, 32'h0, 4'h0, 1'b0, 32'hFFFF_FFFF, 1'b1, 17);
        ar_never = 0;
        chk("timeout_set", {31'h0, bus.timeout}, 32'h1);
        xfer(32'h100, 32'h0, 4'h0, 1'b0, 32'hA5A5_BEEF, 1'b0, 3);
        chk("timeout_sticky", {31'h0, bus.timeout}, 32'h1);
`else
        chk("timeout_tied", {31'h0, bus.timeout}, 32'h0);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("b_count_final", b_count, n_writes);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
